// File: rtl/quadrature_emulator_if.sv
// Host-side channels and encoder pins of the quadrature emulator.
// master = command source / pin consumer, slave = emulator.
interface quadrature_emulator_if #(
  parameter int DIV_W  = 16,
  parameter int STEP_W = 8,
  parameter int PB_W   = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic [DIV_W-1:0]  phase_cycles;
  logic              done;
  logic              pb_valid;
  logic              pb_ready;
  logic [PB_W-1:0]   pb_hold;
  logic              A;
  logic              B;
  logic              PB;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, phase_cycles, pb_valid, pb_hold,
    input  cmd_ready, done, pb_ready, A, B, PB
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, phase_cycles, pb_valid, pb_hold,
    output cmd_ready, done, pb_ready, A, B, PB
  );
endinterface

// File: rtl/quadrature_emulator.sv
// Rotary-encoder waveform generator: emits Gray-coded A/B detent cycles and
// timed active-low pushbutton presses from two independent valid/ready channels.
module quadrature_emulator #(
  parameter int DIV_W  = 16,
  parameter int STEP_W = 8,
  parameter int PB_W   = 12
) (
  input logic                 clk,
  input logic                 rstn,
  quadrature_emulator_if.slave bus
);

  typedef enum logic {S_IDLE, S_RUN}   step_state_e;
  typedef enum logic {P_IDLE, P_PRESS} pb_state_e;

  step_state_e       step_state_q, step_state_d;
  logic [DIV_W-1:0]  phase_cnt_q, phase_cnt_d;
  logic [DIV_W-1:0]  reload_q, reload_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [1:0]        quarter_q, quarter_d;
  logic              dir_q, dir_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic              done_q, done_d;

  pb_state_e         pb_state_q, pb_state_d;
  logic [PB_W-1:0]   pb_cnt_q, pb_cnt_d;
  logic              pb_q, pb_d;

  logic              cmd_accept;
  logic              pb_accept;
  logic [DIV_W-1:0]  phase_m1;
  logic [PB_W-1:0]   hold_m1;

  // CW order is 10,11,01,00; CCW is the same walk with A and B swapped.
  function automatic logic [1:0] quad_code(input logic dir, input logic [1:0] quarter);
    logic [1:0] cw;
    case (quarter)
      2'd0:    cw = 2'b10;
      2'd1:    cw = 2'b11;
      2'd2:    cw = 2'b01;
      default: cw = 2'b00;
    endcase
    return dir ? cw : {cw[0], cw[1]};
  endfunction

  assign bus.cmd_ready = (step_state_q == S_IDLE) && rstn;
  assign bus.pb_ready  = (pb_state_q == P_IDLE) && rstn;
  assign bus.done      = done_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.PB        = pb_q;

  assign cmd_accept = bus.cmd_valid && bus.cmd_ready;
  assign pb_accept  = bus.pb_valid && bus.pb_ready;

  // Zero lengths behave as one cycle, so the reload value saturates at 0.
  assign phase_m1 = (bus.phase_cycles == '0) ? '0 : bus.phase_cycles - 1'b1;
  assign hold_m1  = (bus.pb_hold == '0) ? '0 : bus.pb_hold - 1'b1;

  always_comb begin
    step_state_d = step_state_q;
    phase_cnt_d  = phase_cnt_q;
    reload_d     = reload_q;
    steps_d      = steps_q;
    quarter_d    = quarter_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    case (step_state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          if (bus.cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            step_state_d = S_RUN;
            dir_d        = bus.cmd_dir;
            reload_d     = phase_m1;
            phase_cnt_d  = phase_m1;
            steps_d      = bus.cmd_steps;
            quarter_d    = 2'd0;
          end
        end
      end
      S_RUN: begin
        if (phase_cnt_q != '0) begin
          phase_cnt_d = phase_cnt_q - 1'b1;
        end else begin
          phase_cnt_d = reload_q;
          quarter_d   = quarter_q + 2'd1;
          // Leaving the 00 detent closes one step; the last one ends the command.
          if (quarter_q == 2'd3) begin
            steps_d = steps_q - 1'b1;
            if (steps_q == STEP_W'(1)) begin
              step_state_d = S_IDLE;
              done_d       = 1'b1;
            end
          end
        end
      end
      default: step_state_d = S_IDLE;
    endcase
    {a_d, b_d} = (step_state_d == S_RUN) ? quad_code(dir_d, quarter_d) : 2'b00;
  end

  always_comb begin
    pb_state_d = pb_state_q;
    pb_cnt_d   = pb_cnt_q;
    case (pb_state_q)
      P_IDLE: begin
        if (pb_accept) begin
          pb_state_d = P_PRESS;
          pb_cnt_d   = hold_m1;
        end
      end
      P_PRESS: begin
        if (pb_cnt_q != '0) begin
          pb_cnt_d = pb_cnt_q - 1'b1;
        end else begin
          pb_state_d = P_IDLE;
        end
      end
      default: pb_state_d = P_IDLE;
    endcase
    pb_d = (pb_state_d != P_PRESS);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      step_state_q <= S_IDLE;
      phase_cnt_q  <= '0;
      reload_q     <= '0;
      steps_q      <= '0;
      quarter_q    <= 2'd0;
      dir_q        <= 1'b0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      done_q       <= 1'b0;
      pb_state_q   <= P_IDLE;
      pb_cnt_q     <= '0;
      pb_q         <= 1'b1;
    end else begin
      step_state_q <= step_state_d;
      phase_cnt_q  <= phase_cnt_d;
      reload_q     <= reload_d;
      steps_q      <= steps_d;
      quarter_q    <= quarter_d;
      dir_q        <= dir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      done_q       <= done_d;
      pb_state_q   <= pb_state_d;
      pb_cnt_q     <= pb_cnt_d;
      pb_q         <= pb_d;
    end
  end

endmodule

// File: tb/tb_quadrature_emulator.sv
// Bench for quadrature_emulator: expected A/B waveforms are built as per-cycle
// code lists, and a free-running x4 decoder tracks detent position on the pins.
module tb_quadrature_emulator;
  localparam int DIV_W  = 16;
  localparam int STEP_W = 8;
  localparam int PB_W   = 12;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  quadrature_emulator_if #(.DIV_W(DIV_W), .STEP_W(STEP_W), .PB_W(PB_W)) qif();

  quadrature_emulator #(.DIV_W(DIV_W), .STEP_W(STEP_W), .PB_W(PB_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (qif)
  );

  always #5 clk = ~clk;

  logic [1:0] exp_ab[$];
  logic       mon_en   = 1'b0;
  logic [1:0] mon_prev = 2'b00;
  int         dec_pos  = 32;
  int         gray_err = 0;

  function automatic int code_idx(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Loopback decoder: +1 per CW quarter, -1 per CCW quarter, two-bit jumps are errors.
  always @(negedge clk) begin
    logic [1:0] cur;
    int         d;
    cur = {qif.A, qif.B};
    if (mon_en) begin
      d = (code_idx(cur) - code_idx(mon_prev)) & 3;
      if (d == 1) dec_pos++;
      else if (d == 3) dec_pos--;
      else if (d == 2) gray_err++;
    end
    mon_prev = cur;
  end

  task automatic model_trace(input bit dir, input int steps, input int p);
    logic [1:0] cw [4];
    int         pe;
    cw = '{2'b10, 2'b11, 2'b01, 2'b00};
    pe = (p == 0) ? 1 : p;
    exp_ab.delete();
    for (int s = 0; s < steps; s++)
      for (int q = 0; q < 4; q++)
        for (int k = 0; k < pe; k++)
          exp_ab.push_back(dir ? cw[q] : {cw[q][0], cw[q][1]});
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_cmd(input bit dir, input int steps, input int p);
    qif.cmd_valid    = 1'b1;
    qif.cmd_dir      = dir;
    qif.cmd_steps    = STEP_W'(steps);
    qif.phase_cycles = DIV_W'(p);
    @(negedge clk);
    qif.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({qif.A, qif.B} !== 2'b00 || qif.PB !== 1'b1 || qif.done !== 1'b0 ||
          qif.cmd_ready !== 1'b0 || qif.pb_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got AB=%b PB=%b done=%b crdy=%b prdy=%b want AB=00 PB=1 done=0 crdy=0 prdy=0",
                 {qif.A, qif.B}, qif.PB, qif.done, qif.cmd_ready, qif.pb_ready);
      end
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (qif.cmd_ready !== 1'b1 || qif.pb_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got crdy=%b prdy=%b want 1 1", qif.cmd_ready, qif.pb_ready);
    end
  endtask

  task automatic test_cw;
    mon_en  = 1'b1;
    dec_pos = 32;
    model_trace(1'b1, 3, 2);
    start_cmd(1'b1, 3, 2);
    for (int i = 0; i < exp_ab.size(); i++) begin
      checks++;
      if ({qif.A, qif.B} !== exp_ab[i] || qif.done !== 1'b0 || qif.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL cw_trace[%0d] got AB=%b done=%b crdy=%b want AB=%b done=0 crdy=0",
                 i, {qif.A, qif.B}, qif.done, qif.cmd_ready, exp_ab[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (qif.done !== 1'b1 || {qif.A, qif.B} !== 2'b00 || qif.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cw_done got done=%b AB=%b crdy=%b want 1 00 1", qif.done, {qif.A, qif.B}, qif.cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (qif.done !== 1'b0) begin
      errors++;
      $display("FAIL cw_done_width got done=%b want 0", qif.done);
    end
    checks++;
    if (dec_pos / 4 !== 11) begin
      errors++;
      $display("FAIL cw_decoder got %0d want 11", dec_pos / 4);
    end
  endtask

  task automatic test_ccw;
    dec_pos = 32;
    model_trace(1'b0, 1, 0);
    start_cmd(1'b0, 1, 0);
    for (int i = 0; i < exp_ab.size(); i++) begin
      checks++;
      if ({qif.A, qif.B} !== exp_ab[i] || qif.done !== 1'b0) begin
        errors++;
        $display("FAIL ccw_trace[%0d] got AB=%b done=%b want AB=%b done=0",
                 i, {qif.A, qif.B}, qif.done, exp_ab[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (qif.done !== 1'b1 || {qif.A, qif.B} !== 2'b00) begin
      errors++;
      $display("FAIL ccw_done got done=%b AB=%b want 1 00", qif.done, {qif.A, qif.B});
    end
    @(negedge clk);
    checks++;
    if (dec_pos / 4 !== 7) begin
      errors++;
      $display("FAIL ccw_decoder got %0d want 7", dec_pos / 4);
    end
  endtask

  task automatic test_back_to_back;
    start_cmd(1'b1, 0, 5);
    checks++;
    if (qif.done !== 1'b1 || {qif.A, qif.B} !== 2'b00 || qif.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_steps got done=%b AB=%b crdy=%b want 1 00 1", qif.done, {qif.A, qif.B}, qif.cmd_ready);
    end
    model_trace(1'b1, 1, 1);
    start_cmd(1'b1, 1, 1);
    for (int i = 0; i < exp_ab.size(); i++) begin
      checks++;
      if ({qif.A, qif.B} !== exp_ab[i] || qif.done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_trace[%0d] got AB=%b done=%b want AB=%b done=0",
                 i, {qif.A, qif.B}, qif.done, exp_ab[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (qif.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done got %b want 1", qif.done);
    end
    @(negedge clk);
  endtask

  task automatic test_pb_overlap;
    bit exp_low;
    model_trace(1'b1, 2, 3);
    start_cmd(1'b1, 2, 3);
    for (int i = 0; i < exp_ab.size(); i++) begin
      exp_low = (i > 4) && (i <= 9);
      checks++;
      if ({qif.A, qif.B} !== exp_ab[i] || qif.PB !== !exp_low || qif.pb_ready !== !exp_low) begin
        errors++;
        $display("FAIL pb_overlap[%0d] got AB=%b PB=%b prdy=%b want AB=%b PB=%b prdy=%b",
                 i, {qif.A, qif.B}, qif.PB, qif.pb_ready, exp_ab[i], !exp_low, !exp_low);
      end
      if (i == 4) begin
        qif.pb_valid = 1'b1;
        qif.pb_hold  = PB_W'(5);
      end else begin
        qif.pb_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (qif.done !== 1'b1 || qif.PB !== 1'b1) begin
      errors++;
      $display("FAIL pb_overlap_done got done=%b PB=%b want 1 1", qif.done, qif.PB);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    bit dir;
    int steps, p, n, k, h, heff, pos0;
    bit use_pb, exp_low;
    for (int it = 0; it < 12; it++) begin
      dir   = 1'($urandom_range(0, 1));
      steps = $urandom_range(0, 3);
      p     = $urandom_range(0, 3);
      model_trace(dir, steps, p);
      n      = exp_ab.size();
      use_pb = (n >= 2);
      k      = use_pb ? $urandom_range(0, n - 2) : 0;
      h      = use_pb ? $urandom_range(0, n - 1 - k) : 0;
      heff   = (h == 0) ? 1 : h;
      pos0   = dec_pos;
      checks++;
      if (qif.cmd_ready !== 1'b1 || qif.done !== 1'b0) begin
        errors++;
        $display("FAIL rnd_idle[%0d] got crdy=%b done=%b want 1 0", it, qif.cmd_ready, qif.done);
      end
      start_cmd(dir, steps, p);
      for (int i = 0; i < n; i++) begin
        exp_low = use_pb && (i > k) && (i <= k + heff);
        checks++;
        if ({qif.A, qif.B} !== exp_ab[i] || qif.done !== 1'b0 || qif.PB !== !exp_low) begin
          errors++;
          $display("FAIL rnd_trace[%0d][%0d] dir=%0d steps=%0d p=%0d got AB=%b done=%b PB=%b want AB=%b done=0 PB=%b",
                   it, i, dir, steps, p, {qif.A, qif.B}, qif.done, qif.PB, exp_ab[i], !exp_low);
        end
        qif.pb_valid = use_pb && (i == k);
        qif.pb_hold  = PB_W'(h);
        @(negedge clk);
      end
      qif.pb_valid = 1'b0;
      checks++;
      if (qif.done !== 1'b1 || {qif.A, qif.B} !== 2'b00 || qif.PB !== 1'b1 || qif.pb_ready !== 1'b1) begin
        errors++;
        $display("FAIL rnd_done[%0d] got done=%b AB=%b PB=%b prdy=%b want 1 00 1 1",
                 it, qif.done, {qif.A, qif.B}, qif.PB, qif.pb_ready);
      end
      checks++;
      if (dec_pos - pos0 !== (dir ? 4 * steps : -4 * steps)) begin
        errors++;
        $display("FAIL rnd_decoder[%0d] got %0d want %0d", it, dec_pos - pos0, dir ? 4 * steps : -4 * steps);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    qif.pb_valid = 1'b1;
    qif.pb_hold  = PB_W'(20);
    start_cmd(1'b1, 2, 2);
    qif.pb_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({qif.A, qif.B} !== 2'b11 || qif.PB !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre got AB=%b PB=%b want 11 0", {qif.A, qif.B}, qif.PB);
    end
    mon_en        = 1'b0;
    rstn          = 1'b0;
    qif.cmd_valid = 1'b1;
    qif.cmd_steps = STEP_W'(1);
    qif.pb_valid  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({qif.A, qif.B} !== 2'b00 || qif.PB !== 1'b1 || qif.done !== 1'b0 ||
          qif.cmd_ready !== 1'b0 || qif.pb_ready !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_hold got AB=%b PB=%b done=%b crdy=%b prdy=%b want 00 1 0 0 0",
                 {qif.A, qif.B}, qif.PB, qif.done, qif.cmd_ready, qif.pb_ready);
      end
    end
    rstn          = 1'b1;
    qif.cmd_valid = 1'b0;
    qif.pb_valid  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({qif.A, qif.B} !== 2'b00 || qif.PB !== 1'b1 || qif.done !== 1'b0 || qif.cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_after got AB=%b PB=%b done=%b crdy=%b want 00 1 0 1",
                 {qif.A, qif.B}, qif.PB, qif.done, qif.cmd_ready);
      end
    end
    mon_en = 1'b1;
  endtask

  task automatic test_gray;
    checks++;
    if (gray_err !== 0) begin
      errors++;
      $display("FAIL gray_code got %0d double-bit transitions want 0", gray_err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    qif.cmd_valid    = 1'b0;
    qif.cmd_dir      = 1'b0;
    qif.cmd_steps    = '0;
    qif.phase_cycles = '0;
    qif.pb_valid     = 1'b0;
    qif.pb_hold      = '0;
    @(posedge clk);
    test_reset();
    test_cw();
    test_ccw();
    test_back_to_back();
    test_pb_overlap();
    test_random();
    test_reset_mid();
    test_random();
    test_gray();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
